// File: rtl/triangle_setup.sv
// Triangle setup: latches a screen-space triangle, computes its clamped bounding box and
// twice its signed area, and discards degenerate or offscreen triangles.
// Optional macro TRIANGLE_SETUP_BACKFACE_CULL_EN also discards clockwise (negative-area) triangles.
module triangle_setup #(
    parameter int unsigned SCREEN_W = 1280,
    parameter int unsigned SCREEN_H = 720
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0][2:0][10:0]  triangle_2d,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2:0][2:0][10:0]  tri_out,
    output logic [10:0]            bbox_xmin,
    output logic [10:0]            bbox_xmax,
    output logic [10:0]            bbox_ymin,
    output logic [10:0]            bbox_ymax,
    output logic signed [24:0]     area2,
    output logic [15:0]            drop_count
);

    localparam logic [10:0] XLIM = 11'(SCREEN_W - 1);
    localparam logic [10:0] YLIM = 11'(SCREEN_H - 1);

    typedef enum logic [2:0] {IDLE, BBOX, MUL0, MUL1, OUT} state_t;

    state_t             state_q;
    logic signed [11:0] dx1_q, dy1_q, dx2_q, dy2_q;
    logic signed [23:0] p0_q;

    logic [10:0]        x0, y0, x1, y1, x2, y2;
    logic [10:0]        xmin_d, xmax_d, ymin_d, ymax_d;
    logic signed [11:0] dx1_d, dy1_d, dx2_d, dy2_d;
    logic signed [23:0] p0_d, p1_d;
    logic signed [24:0] area2_d;
    logic               drop_d;

    assign x0 = tri_out[0][0];
    assign y0 = tri_out[0][1];
    assign x1 = tri_out[1][0];
    assign y1 = tri_out[1][1];
    assign x2 = tri_out[2][0];
    assign y2 = tri_out[2][1];

    // Datapath for the latched triangle; each term is consumed in its own FSM state.
    always_comb begin
        xmin_d = x0;
        xmax_d = x0;
        ymin_d = y0;
        ymax_d = y0;
        if (x1 < xmin_d) xmin_d = x1;
        if (x2 < xmin_d) xmin_d = x2;
        if (x1 > xmax_d) xmax_d = x1;
        if (x2 > xmax_d) xmax_d = x2;
        if (y1 < ymin_d) ymin_d = y1;
        if (y2 < ymin_d) ymin_d = y2;
        if (y1 > ymax_d) ymax_d = y1;
        if (y2 > ymax_d) ymax_d = y2;

        dx1_d = $signed({1'b0, x1}) - $signed({1'b0, x0});
        dy1_d = $signed({1'b0, y1}) - $signed({1'b0, y0});
        dx2_d = $signed({1'b0, x2}) - $signed({1'b0, x0});
        dy2_d = $signed({1'b0, y2}) - $signed({1'b0, y0});

        p0_d    = dx1_q * dy2_q;
        p1_d    = dx2_q * dy1_q;
        area2_d = $signed({p0_q[23], p0_q}) - $signed({p1_d[23], p1_d});

        drop_d = (area2_d == 25'sd0) || (bbox_xmin > XLIM) || (bbox_ymin > YLIM);
`ifdef TRIANGLE_SETUP_BACKFACE_CULL_EN
        if (area2_d[24]) drop_d = 1'b1;
`else
`endif
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            tri_out    <= '0;
            bbox_xmin  <= '0;
            bbox_xmax  <= '0;
            bbox_ymin  <= '0;
            bbox_ymax  <= '0;
            area2      <= '0;
            drop_count <= '0;
            dx1_q      <= '0;
            dy1_q      <= '0;
            dx2_q      <= '0;
            dy2_q      <= '0;
            p0_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        tri_out  <= triangle_2d;
                        in_ready <= 1'b0;
                        state_q  <= BBOX;
                    end
                end
                BBOX: begin
                    bbox_xmin <= xmin_d;
                    bbox_ymin <= ymin_d;
                    bbox_xmax <= (xmax_d > XLIM) ? XLIM : xmax_d;
                    bbox_ymax <= (ymax_d > YLIM) ? YLIM : ymax_d;
                    dx1_q     <= dx1_d;
                    dy1_q     <= dy1_d;
                    dx2_q     <= dx2_d;
                    dy2_q     <= dy2_d;
                    state_q   <= MUL0;
                end
                MUL0: begin
                    p0_q    <= p0_d;
                    state_q <= MUL1;
                end
                MUL1: begin
                    area2 <= area2_d;
                    if (drop_d) begin
                        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
                        in_ready <= 1'b1;
                        state_q  <= IDLE;
                    end else begin
                        out_valid <= 1'b1;
                        state_q   <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_triangle_setup.sv
// Self-checking bench for triangle_setup: directed corner cases plus random triangles
// checked against an arithmetic reference model.
module tb_triangle_setup;

    localparam int W = 1280;
    localparam int H = 720;

    typedef logic [2:0][2:0][10:0] tri_t;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    tri_t               triangle_2d;
    logic               out_valid;
    logic               out_ready;
    tri_t               tri_out;
    logic [10:0]        bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax;
    logic signed [24:0] area2;
    logic [15:0]        drop_count;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_drops = 0;

    triangle_setup #(.SCREEN_W(W), .SCREEN_H(H)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .triangle_2d(triangle_2d),
        .out_valid(out_valid), .out_ready(out_ready), .tri_out(tri_out),
        .bbox_xmin(bbox_xmin), .bbox_xmax(bbox_xmax),
        .bbox_ymin(bbox_ymin), .bbox_ymax(bbox_ymax),
        .area2(area2), .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic tri_t mk(input int x0, input int y0, input int x1, input int y1,
                                input int x2, input int y2);
        tri_t t;
        t[0][0] = 11'(x0); t[0][1] = 11'(y0); t[0][2] = 11'($urandom_range(0, 2047));
        t[1][0] = 11'(x1); t[1][1] = 11'(y1); t[1][2] = 11'($urandom_range(0, 2047));
        t[2][0] = 11'(x2); t[2][1] = 11'(y2); t[2][2] = 11'($urandom_range(0, 2047));
        return t;
    endfunction

    // Reference: cross product of edge vectors, axis-aligned extents, drop rules.
    function automatic void model(input tri_t t, output longint ar, output int xmn,
                                  output int xmx, output int ymn, output int ymx,
                                  output bit drop);
        int x[3];
        int y[3];
        for (int v = 0; v < 3; v++) begin
            x[v] = int'(t[v][0]);
            y[v] = int'(t[v][1]);
        end
        ar  = longint'((x[1] - x[0]) * (y[2] - y[0])) - longint'((x[2] - x[0]) * (y[1] - y[0]));
        xmn = x[0]; xmx = x[0]; ymn = y[0]; ymx = y[0];
        for (int v = 1; v < 3; v++) begin
            if (x[v] < xmn) xmn = x[v];
            if (x[v] > xmx) xmx = x[v];
            if (y[v] < ymn) ymn = y[v];
            if (y[v] > ymx) ymx = y[v];
        end
        if (xmx > W - 1) xmx = W - 1;
        if (ymx > H - 1) ymx = H - 1;
        drop = (ar == 0) || (xmn > W - 1) || (ymn > H - 1);
`ifdef TRIANGLE_SETUP_BACKFACE_CULL_EN
        if (ar < 0) drop = 1'b1;
`endif
    endfunction

    task automatic check_result(input string tag, input tri_t t, input longint ar,
                                input int xmn, input int xmx, input int ymn, input int ymx);
        check({tag, ".valid"}, longint'(out_valid), 1);
        check({tag, ".in_ready"}, longint'(in_ready), 0);
        check({tag, ".area2"}, longint'(area2), ar);
        check({tag, ".xmin"}, longint'(bbox_xmin), longint'(xmn));
        check({tag, ".xmax"}, longint'(bbox_xmax), longint'(xmx));
        check({tag, ".ymin"}, longint'(bbox_ymin), longint'(ymn));
        check({tag, ".ymax"}, longint'(bbox_ymax), longint'(ymx));
        for (int v = 0; v < 3; v++)
            check($sformatf("%s.tri%0d", tag, v), longint'(tri_out[v]), longint'(t[v]));
    endtask

    // Called and returns at a negedge with the DUT idle.
    task automatic run_tri(input string tag, input tri_t t, input int stall);
        longint ar;
        int     xmn, xmx, ymn, ymx;
        bit     drop;
        model(t, ar, xmn, xmx, ymn, ymx, drop);
        check({tag, ".ready_pre"}, longint'(in_ready), 1);
        triangle_2d = t;
        in_valid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check({tag, ".lat1"}, longint'(out_valid), 0);
        check({tag, ".busy"}, longint'(in_ready), 0);
        triangle_2d = mk($urandom_range(0, 2047), $urandom_range(0, 2047), 0, 0, 5, 9);
        @(posedge clk);
        @(negedge clk);
        check({tag, ".lat2"}, longint'(out_valid), 0);
        @(posedge clk);
        @(negedge clk);
        check({tag, ".lat3"}, longint'(out_valid), 0);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if (drop) begin
            exp_drops++;
            check({tag, ".drop_valid"}, longint'(out_valid), 0);
            check({tag, ".drop_ready"}, longint'(in_ready), 1);
            check({tag, ".drop_count"}, longint'(drop_count), longint'(exp_drops));
            return;
        end
        check_result(tag, t, ar, xmn, xmx, ymn, ymx);
        check({tag, ".drop_count"}, longint'(drop_count), longint'(exp_drops));
        for (int i = 0; i < stall; i++) begin
            out_ready   = 1'b0;
            in_valid    = 1'b1;
            triangle_2d = mk(1, 2, 3, 4, 5, 6);
            @(posedge clk);
            @(negedge clk);
            check_result($sformatf("%s.hold%0d", tag, i), t, ar, xmn, xmx, ymn, ymx);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ".done_valid"}, longint'(out_valid), 0);
        check({tag, ".done_ready"}, longint'(in_ready), 1);
    endtask

    initial begin
        tri_t t;
        int   mode;
        rst         = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        triangle_2d = '0;
        repeat (2) @(negedge clk);
        check("rst.in_ready", longint'(in_ready), 1);
        check("rst.out_valid", longint'(out_valid), 0);
        check("rst.drop_count", longint'(drop_count), 0);
        check("rst.area2", longint'(area2), 0);
        check("rst.bbox", longint'({bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax}), 0);
        check("rst.tri_out", longint'(tri_out[0] | tri_out[1] | tri_out[2]), 0);
        rst = 1'b0;

        run_tri("ccw", mk(0, 0, 10, 0, 0, 10), 0);
        run_tri("cw", mk(0, 0, 0, 10, 10, 0), 1);
        run_tri("collinear", mk(0, 0, 5, 5, 10, 10), 0);
        run_tri("offscreen_x", mk(1500, 0, 1600, 0, 1550, 10), 0);
        run_tri("offscreen_y", mk(0, 800, 10, 900, 5, 760), 0);
        run_tri("clamp", mk(1200, 700, 1400, 700, 1200, 800), 10);
        run_tri("edge", mk(1279, 719, 2047, 719, 1279, 2047), 2);

        // Reset while the triangle sits in MUL0.
        triangle_2d = mk(0, 0, 10, 0, 0, 10);
        in_valid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mrst.out_valid", longint'(out_valid), 0);
        check("mrst.in_ready", longint'(in_ready), 1);
        check("mrst.drop_count", longint'(drop_count), 0);
        check("mrst.area2", longint'(area2), 0);
        exp_drops = 0;
        @(negedge clk);
        rst = 1'b0;
        run_tri("post_rst", mk(100, 100, 300, 150, 120, 400), 1);
        check("post_rst.drop_count", longint'(drop_count), 0);

        for (int n = 0; n < 60; n++) begin
            mode = int'($urandom_range(0, 9));
            if (mode < 6)
                t = mk($urandom_range(0, 1400), $urandom_range(0, 800), $urandom_range(0, 1400),
                       $urandom_range(0, 800), $urandom_range(0, 1400), $urandom_range(0, 800));
            else if (mode < 8)
                t = mk($urandom_range(0, 2047), $urandom_range(0, 2047), $urandom_range(0, 2047),
                       $urandom_range(0, 2047), $urandom_range(0, 2047), $urandom_range(0, 2047));
            else begin
                t = mk($urandom_range(0, 1000), $urandom_range(0, 600), $urandom_range(0, 1000),
                       $urandom_range(0, 600), 0, 0);
                t[2] = t[mode - 8];
            end
            run_tri($sformatf("rnd%0d", n), t, int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
